// File: rtl/tone_sequencer.sv
// Pattern step sequencer: walks a 16-entry note pattern and drives the oscillator phase
// increment plus a note gate. Step timing is counted in synchronized lrclk sample ticks.
module tone_sequencer #(
    parameter int PHASE_SIZE = 16,
    parameter int NOTE_BITS  = 8,
    parameter int STEP_BITS  = 4,
    parameter int TEMPO_BITS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lrclk,
    input  logic                  start,
    input  logic                  stop,
    input  logic [STEP_BITS-1:0]  length,
    input  logic [TEMPO_BITS-1:0] step_samples,
    input  logic [TEMPO_BITS-1:0] gate_samples,
    input  logic                  wr_en,
    input  logic [STEP_BITS-1:0]  wr_addr,
    input  logic [NOTE_BITS-1:0]  wr_note,
    input  logic                  wr_rest,
    output logic [NOTE_BITS-1:0]  tone_idx,
    input  logic [PHASE_SIZE-1:0] tone_freq,
    output logic [PHASE_SIZE-1:0] freq,
    output logic                  gate,
    output logic [STEP_BITS-1:0]  step_idx,
    output logic                  step_pulse,
    output logic                  running
);

    localparam int DEPTH = 1 << STEP_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOOKUP,
        S_ARM,
        S_PLAY
    } state_t;

    state_t state_q, state_d;

    logic lrclk_meta_q, lrclk_sync_q, lrclk_prev_q;
    logic sample_tick;

    // Bit NOTE_BITS of each entry is the rest flag, the rest is the note index.
    logic [NOTE_BITS:0] pat_q [DEPTH];

    logic [STEP_BITS-1:0]  ptr_q, ptr_d;
    logic [STEP_BITS-1:0]  step_idx_q, step_idx_d;
    logic [NOTE_BITS-1:0]  tone_idx_q, tone_idx_d;
    logic                  rest_q, rest_d;
    logic [PHASE_SIZE-1:0] pending_freq_q, pending_freq_d;
    logic [PHASE_SIZE-1:0] freq_q, freq_d;
    logic                  gate_q, gate_d;
    logic                  step_pulse_q, step_pulse_d;
    logic [TEMPO_BITS-1:0] cnt_q, cnt_d;

    logic [TEMPO_BITS-1:0] eff_step;
    logic [TEMPO_BITS-1:0] cnt_inc;
    logic [STEP_BITS-1:0]  next_ptr;
    logic                  active;

    assign sample_tick = lrclk_sync_q & ~lrclk_prev_q;
    assign active      = (state_q != S_IDLE);
    assign eff_step    = (step_samples == '0) ? TEMPO_BITS'(1) : step_samples;
    assign cnt_inc     = cnt_q + 1'b1;
    assign next_ptr    = (ptr_q >= length) ? '0 : ptr_q + 1'b1;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            pat_q[wr_addr] <= {wr_rest, wr_note};
        end
    end

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        step_idx_d     = step_idx_q;
        tone_idx_d     = tone_idx_q;
        rest_d         = rest_q;
        pending_freq_d = pending_freq_q;
        freq_d         = freq_q;
        gate_d         = gate_q;
        step_pulse_d   = 1'b0;
        cnt_d          = cnt_q;

        if (active && stop) begin
            state_d = S_IDLE;
            gate_d  = 1'b0;
        end else if (start && !stop) begin
            // Restart from either idle or mid-pattern; the gate closes while refetching.
            state_d    = S_FETCH;
            ptr_d      = '0;
            step_idx_d = '0;
            gate_d     = 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    tone_idx_d = pat_q[ptr_q][NOTE_BITS-1:0];
                    rest_d     = pat_q[ptr_q][NOTE_BITS];
                    state_d    = S_LOOKUP;
                end
                S_LOOKUP: begin
                    pending_freq_d = tone_freq;
                    state_d        = S_ARM;
                end
                S_ARM: begin
                    if (sample_tick) begin
                        if (!rest_q) begin
                            freq_d = pending_freq_q;
                        end
                        gate_d       = !rest_q && (gate_samples != '0);
                        step_idx_d   = ptr_q;
                        step_pulse_d = 1'b1;
                        cnt_d        = TEMPO_BITS'(1);
                        // A one-sample step ends on its own start tick.
                        if (eff_step == TEMPO_BITS'(1)) begin
                            ptr_d   = next_ptr;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_PLAY;
                        end
                    end
                end
                S_PLAY: begin
                    if (sample_tick) begin
                        cnt_d = cnt_inc;
                        // Compare the pre-increment count so the gate spans gate_samples ticks
                        // and never drops at a step boundary when gate_samples >= step length.
                        if (cnt_q == gate_samples) begin
                            gate_d = 1'b0;
                        end
                        if (cnt_inc == eff_step) begin
                            ptr_d   = next_ptr;
                            state_d = S_FETCH;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            lrclk_meta_q   <= 1'b0;
            lrclk_sync_q   <= 1'b0;
            lrclk_prev_q   <= 1'b0;
            ptr_q          <= '0;
            step_idx_q     <= '0;
            tone_idx_q     <= '0;
            rest_q         <= 1'b0;
            pending_freq_q <= '0;
            freq_q         <= '0;
            gate_q         <= 1'b0;
            step_pulse_q   <= 1'b0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            lrclk_meta_q   <= lrclk;
            lrclk_sync_q   <= lrclk_meta_q;
            lrclk_prev_q   <= lrclk_sync_q;
            ptr_q          <= ptr_d;
            step_idx_q     <= step_idx_d;
            tone_idx_q     <= tone_idx_d;
            rest_q         <= rest_d;
            pending_freq_q <= pending_freq_d;
            freq_q         <= freq_d;
            gate_q         <= gate_d;
            step_pulse_q   <= step_pulse_d;
            cnt_q          <= cnt_d;
        end
    end

    assign tone_idx   = tone_idx_q;
    assign freq       = freq_q;
    assign gate       = gate_q;
    assign step_idx   = step_idx_q;
    assign step_pulse = step_pulse_q;
    assign running    = active;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed and randomized checks of tone_sequencer against a step-level reference model
// (expected step order, held frequency, gate length and step spacing in clock cycles).
module tb_tone_sequencer;

  localparam int LR_HALF = 4;
  localparam int LR_PER  = 2 * LR_HALF;

  logic        clk = 1'b0;
  logic        reset;
  logic        lrclk = 1'b0;
  logic        start, stop;
  logic [3:0]  length;
  logic [15:0] step_samples, gate_samples;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_note;
  logic        wr_rest;
  logic [7:0]  tone_idx;
  logic [15:0] tone_freq;
  logic [15:0] freq;
  logic        gate;
  logic [3:0]  step_idx;
  logic        step_pulse;
  logic        running;

  int vectors    = 0;
  int miscompares = 0;

  logic [7:0]  m_note [16];
  bit          m_rest [16];
  int          m_len, m_step, m_gate, m_last;
  bit          m_fresh;
  logic [15:0] m_freq;

  tone_sequencer dut (
    .clk(clk), .reset(reset), .lrclk(lrclk), .start(start), .stop(stop),
    .length(length), .step_samples(step_samples), .gate_samples(gate_samples),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_note(wr_note), .wr_rest(wr_rest),
    .tone_idx(tone_idx), .tone_freq(tone_freq), .freq(freq), .gate(gate),
    .step_idx(step_idx), .step_pulse(step_pulse), .running(running)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (LR_HALF) @(negedge clk);
      lrclk = ~lrclk;
    end
  end

  function automatic logic [15:0] rom(input logic [7:0] i);
    return 16'(i) * 16'd389 + 16'd1234;
  endfunction

  assign tone_freq = rom(tone_idx);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input logic [7:0] n, input bit r);
    wr_en = 1'b1; wr_addr = 4'(a); wr_note = n; wr_rest = r;
    @(negedge clk);
    wr_en = 1'b0;
    m_note[a] = n; m_rest[a] = r;
  endtask

  task automatic cfg(input int len, input int stp, input int gt);
    length = 4'(len); step_samples = 16'(stp); gate_samples = 16'(gt);
    m_len = len; m_step = stp; m_gate = gt;
  endtask

  task automatic do_start(input bit was_running);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_fresh = 1'b1;
    check("running_after_start", running, 1);
    if (was_running) check("gate_drop_on_restart", gate, 0);
  endtask

  // Waits for n applied steps and checks each against the model; between consecutive
  // steps it also checks spacing, gate-high time and that freq never moved off a step.
  task automatic play_steps(input int n);
    int clks, ghi, fchg, exp_clks, exp_ghi, e, eff;
    bit have_prev, eg;
    logic [15:0] lastf;
    have_prev = 0; ghi = 0; fchg = 0; exp_clks = 0; exp_ghi = 0;
    lastf = freq;
    for (int k = 0; k < n; k++) begin
      clks = 0;
      do begin
        @(negedge clk);
        clks++;
        if (!step_pulse) begin
          if (gate) ghi++;
          if (freq !== lastf) fchg++;
          lastf = freq;
        end
      end while (!step_pulse && clks < 600);
      if (!step_pulse) begin
        check("step_timeout", step_pulse, 1);
        return;
      end
      if (have_prev) begin
        check("step_spacing_clks", clks, exp_clks);
        check("gate_high_clks", ghi, exp_ghi);
        check("freq_change_off_step", fchg, 0);
      end
      e = m_fresh ? 0 : ((m_last >= m_len) ? 0 : m_last + 1);
      m_fresh = 1'b0;
      m_last = e;
      if (!m_rest[e]) m_freq = rom(m_note[e]);
      eg = !m_rest[e] && (m_gate != 0);
      check("step_idx", step_idx, e);
      check("freq", freq, m_freq);
      check("gate_at_step", gate, eg);
      eff = (m_step == 0) ? 1 : m_step;
      exp_clks = eff * LR_PER;
      exp_ghi = !eg ? 0 : ((m_gate >= eff) ? eff * LR_PER : m_gate * LR_PER);
      ghi = gate ? 1 : 0;
      fchg = 0;
      lastf = freq;
      have_prev = 1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_freq"}, freq, 0);
    check({tag, "_gate"}, gate, 0);
    check({tag, "_step_idx"}, step_idx, 0);
    check({tag, "_step_pulse"}, step_pulse, 0);
    check({tag, "_running"}, running, 0);
    check({tag, "_tone_idx"}, tone_idx, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; wr_en = 1'b0;
    wr_addr = '0; wr_note = '0; wr_rest = 1'b0;
    m_freq = '0; m_fresh = 1'b1; m_last = 0;
    for (int i = 0; i < 16; i++) begin
      m_note[i] = '0; m_rest[i] = 1'b0;
    end
    cfg(0, 1, 0);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    for (int i = 0; i < 16; i++) wr(i, 8'(i), 1'b0);

    // Basic two-note pattern
    wr(0, 8'd57, 1'b0);
    wr(1, 8'd69, 1'b0);
    cfg(1, 4, 2);
    do_start(1'b0);
    play_steps(4);

    // Reset held two clocks mid-play
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midplay_reset");
    @(negedge clk);
    reset = 1'b0;
    m_freq = '0;
    @(negedge clk);
    check_reset_outputs("after_reset");

    // Rest on step 1
    wr(1, 8'd69, 1'b1);
    do_start(1'b0);
    play_steps(4);

    // Legato gate
    wr(1, 8'd69, 1'b0);
    cfg(1, 4, 8);
    do_start(1'b1);
    play_steps(5);

    // Stop alone: freq held, gate closed
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_gate", gate, 0);
    check("stop_running", running, 0);
    check("stop_freq_hold", freq, m_freq);
    repeat (20) @(negedge clk);
    check("idle_freq_hold", freq, m_freq);

    // Start/stop collision while running
    cfg(1, 3, 1);
    do_start(1'b0);
    play_steps(1);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("collision_running", running, 0);
    check("collision_gate", gate, 0);
    repeat (3) @(negedge clk);
    check("collision_stays_idle", running, 0);
    do_start(1'b0);
    play_steps(3);

    // step_samples=0 advances every tick
    wr(2, 8'd90, 1'b0);
    cfg(2, 0, 0);
    do_start(1'b1);
    play_steps(6);
    cfg(2, 0, 1);
    do_start(1'b1);
    play_steps(4);

    // length=0 repeats step 0, then a write to step 1 during step 0
    cfg(0, 2, 1);
    do_start(1'b1);
    play_steps(3);
    cfg(1, 2, 1);
    play_steps(1);
    wr(1, 8'd101, 1'b0);
    play_steps(4);

    // Randomized patterns, tempo, gate, length changes and restarts
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 16; i++) wr(i, 8'($urandom_range(0, 139)), ($urandom_range(0, 3) == 0));
      cfg($urandom_range(0, 15), $urandom_range(0, 5), $urandom_range(0, 6));
      do_start(running);
      play_steps(6);
      length = 4'($urandom_range(0, 15));
      m_len = int'(length);
      play_steps(6);
      if ($urandom_range(0, 1) == 1) begin
        do_start(1'b1);
        play_steps(3);
      end
    end

    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("final_stop_running", running, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Step sequencer that drives the phase-increment word of a sine generator from a programmable pattern of chromatic note indices.
- Replaces ad-hoc tone stepping on a divided clock: tempo is counted in audio samples and frequency changes land on sample boundaries.
- Sits between the tone table ROM (140 x 16-bit) and the oscillator `freq` input; also produces a gate for downstream envelope/mute logic.

Parameters:
- PHASE_SIZE, 16, width of phase-increment word (`freq`, `tone_freq`)
- NOTE_BITS, 8, width of tone table index
- STEP_BITS, 4, log2 of pattern depth (16 steps)
- TEMPO_BITS, 16, width of samples-per-step and gate-length counters

Ports:
- clk  in  1  system clock (divided OSC domain)
- reset  in  1  synchronous, active-high reset
- lrclk  in  1  codec DAC LR clock, asynchronous to clk
- start  in  1  one-cycle pulse: begin playing at step 0
- stop  in  1  one-cycle pulse: halt, close gate
- length  in  STEP_BITS  last step index (pattern wraps after it)
- step_samples  in  TEMPO_BITS  samples per step; 0 treated as 1
- gate_samples  in  TEMPO_BITS  samples gate stays high per step
- wr_en  in  1  pattern write strobe
- wr_addr  in  STEP_BITS  pattern write address
- wr_note  in  NOTE_BITS  note index to store
- wr_rest  in  1  stored step is a rest
- tone_idx  out  NOTE_BITS  address to tone table ROM
- tone_freq  in  PHASE_SIZE  ROM data, valid exactly 1 clk after tone_idx changes
- freq  out  PHASE_SIZE  phase increment to oscillator
- gate  out  1  note on
- step_idx  out  STEP_BITS  step currently sounding
- step_pulse  out  1  one-cycle pulse when a new step is applied
- running  out  1  sequencer active

Behaviour:
- Reset values: freq=0, gate=0, step_idx=0, step_pulse=0, running=0, tone_idx=0; state=IDLE. Pattern RAM is not cleared.
- lrclk: 2-flop synchronizer plus edge detect. sample_tick is a 1-clk pulse on each synchronized rising edge.
- Pattern RAM: 2^STEP_BITS x (NOTE_BITS+1), written on wr_en at any time.
  - A write to the step currently being fetched takes effect next pass.
- State machine:
  - IDLE: running=0. On start, step_idx←0 and go to FETCH.
  - FETCH (1 clk): read pattern[ptr], drive tone_idx←note, latch rest flag. Next is LOOKUP.
  - LOOKUP (1 clk): capture tone_freq into pending_freq. Next is ARM.
  - ARM: wait for sample_tick. On the tick, in the same clk:
    - freq←pending_freq, unless rest, in which case freq holds its prior value
    - gate←!rest && gate_samples!=0
    - step_idx←ptr, step_pulse=1, sample counter←1
    - go to PLAY
  - PLAY, on each sample_tick:
    - counter increments
    - when counter==gate_samples, gate←0
    - when counter==max(step_samples,1), ptr←(ptr==length)?0:ptr+1 and go to FETCH
    - If gate_samples ≥ step_samples, gate stays high across the boundary; no release glitch.
- Next-step latency: FETCH+LOOKUP take 2 clks, then ARM applies the note on the following tick. Step duration is therefore exactly step_samples ticks, provided the clk/sample ratio is >4.
- running=1 in every state except IDLE.
- stop (any state except IDLE) → next clk: gate=0, running=0, IDLE. freq holds its last value.
  - step_idx also holds its last value.
- start while running: restart at step 0 from FETCH; gate drops for the refetch.
- start and stop in the same clk: stop wins.
- length is sampled at each wrap decision, so a change takes effect at the next step boundary.
  - If ptr>length after a change, the next step is 0.
- Reset mid-operation returns all outputs to reset values on the next clk.

Test Plan:
- Reset: assert reset 2 clks mid-PLAY → freq=0, gate=0, running=0, step_idx=0 on the following clk.
- Basic play: pattern {0:note 57, 1:note 69}, length=1, step_samples=4, gate_samples=2, start. Required response:
  - freq=ROM[57] on first tick after start, gate high for 2 ticks
  - freq=ROM[69] exactly 4 ticks later
  - step_idx sequence 0,1,0,1
- Rest step: step1 flagged rest → gate stays 0 for step 1 and freq holds ROM[57]; step_pulse still fires.
- Legato: gate_samples=8, step_samples=4 → gate never deasserts across steps; freq changes only coincident with sample_tick.
- Stop/start collision: pulse start and stop same clk while running → IDLE, gate=0, running=0. Then start alone → step 0 applied on next tick.
- Boundary: step_samples=0 advances every tick; length=0 repeats step 0; a wr_en to step 1 during step 0 plays the new note on the next pass.
